vga_sync_decoder: RTL and testbench
===================================

// Module: vga_sync_decoder
// PURPOSE
//  Receive side of the VGA pixel interface: samples h_sync/v_sync/RGB from a VGA source, measures line and
//  frame timing, and declares lock after LOCK_FRAMES consecutive frames match the nominal timing.
//  While locked, recovers pixel coordinates and emits a qualified pixel stream for capture or checking logic.
//  Clocked at the source pixel clock (CLOCK_50 domain at top level). Syncs are active-high.
// PARAMETERS
//  H_TOTAL      1041  clocks per line, hs rise to hs rise
//  V_TOTAL      667   lines per frame, vs rise to vs rise
//  H_BP         184   clocks from hs rise to first visible pixel
//  H_ACTIVE     799   visible pixels per line
//  V_BP         29    lines from vs rise to first visible line
//  V_ACTIVE     599   visible lines per frame
//  LOCK_FRAMES  2     consecutive good frames required to lock (1..15)
// PORTS
//  clk           in   1   pixel clock
//  reset         in   1   synchronous, active-high reset
//  h_sync        in   1   horizontal sync, active-high
//  v_sync        in   1   vertical sync, active-high
//  r_in,g_in,b_in in  4   colour inputs (each 4 bits)
//  locked        out  1   timing lock
//  lost          out  1   1-cycle pulse on LOCKED->SEARCH
//  frame_start   out  1   1-cycle pulse on every detected vs rise
//  pix_valid     out  1   pix_* valid (locked and in visible window)
//  pix_x         out  11  column 0..H_ACTIVE-1
//  pix_y         out  11  row 0..V_ACTIVE-1
//  pix_r,pix_g,pix_b out 4 captured colour (each 4 bits)
//  meas_h_period out  11  last measured line period (clocks)
//  meas_v_lines  out  11  last measured lines per frame
//  err_count     out  8   bad frames counted since reset, saturates at 255
// BEHAVIOUR
//  Input stage: h_sync, v_sync and RGB registered once (s_*); edges found against one further delayed copy.
//  hs_rise = s_hs & ~s_hs_d; vs_rise likewise.
//  h_cnt (11b): h_pos = hs_rise ? 0 : h_cnt; h_cnt <= sat(h_pos+1), saturating at 2047.
//  On hs_rise: meas_h_period <= h_cnt. If h_cnt != H_TOTAL, frame_bad <= 1.
//  v_line (11b, saturating): +1 on each hs_rise.
//  Reaching h_cnt == 2047 (no hsync) sets frame_bad.
//  On vs_rise: meas_v_lines <= v_line (including an hs_rise in the same cycle).
//   Frame is good iff v_line == V_TOTAL and frame_bad == 0.
//   Then v_line <= 0 and frame_bad <= 0. The frame_start pulse occurs in this same cycle.
//  FSM:
//   SEARCH: on first vs_rise -> CHECK with good_cnt = 0; no frame evaluation is done.
//   CHECK: on vs_rise, a good frame increments good_cnt; reaching LOCK_FRAMES -> LOCKED.
//    A bad frame sets good_cnt = 0 and stays in CHECK.
//   LOCKED: on vs_rise, a bad frame -> SEARCH with lost = 1 for 1 cycle. Good frames remain LOCKED.
//  err_count increments on each bad frame evaluated in CHECK or LOCKED.
//  locked = (state == LOCKED), registered.
//  Pixel path: pix_valid <= locked & (H_BP <= h_pos < H_BP+H_ACTIVE) & (V_BP <= v_line < V_BP+V_ACTIVE).
//   pix_x <= h_pos - H_BP; pix_y <= v_line - V_BP; pix_rgb <= s_rgb.
//   All pixel outputs are registered: an input pixel on pins at edge k appears on outputs after edge k+2.
//   When pix_valid = 0, pix_x, pix_y and pix_rgb hold 0.
//  Reset (synchronous, priority over everything): state SEARCH, all counters 0, all outputs 0.
//   Input/edge registers are cleared to 0, so a sync already high at reset release is seen as a rising edge.
//  Reset mid-frame or while locked: locked = 0 after the reset edge; relock requires the full SEARCH->CHECK sequence.
// TESTING
//  1 Reset asserted 3 cycles with syncs toggling -> all outputs 0, err_count 0, state SEARCH.
//  2 Nominal source (1041 clocks/line, hs high clocks 57..175, 667 lines, vs high lines 38..42)
//    -> meas_h_period = 1041, meas_v_lines = 667.
//    -> locked rises 1 cycle after the 3rd detected vs_rise (LOCK_FRAMES = 2).
//  3 Locked; drive RGB f/f/0 only at clock H_BP after hs rise on line V_BP
//    -> 2 cycles later pix_valid = 1, x = 0, y = 0, rgb f/f/0.
//    -> Last pixel of the frame shows x = 798, y = 598.
//  4 Locked; one line shortened to 1040 clocks -> at the next vs_rise lost pulses, locked = 0, err_count = 1.
//  5 h_sync held low for one full frame in CHECK -> h_cnt saturates at 2047, frame bad, good_cnt = 0, no lock.
//  6 Reset asserted mid-line while locked -> locked = 0 and pix_valid = 0 next cycle.
//    -> Relocks after 3 vs_rise edges.

Source files
------------

// File: rtl/vga_sync_decoder_if.sv
// VGA receive-side bundle: sync/colour from the source plus the decoded pixel stream and timing status.
// The source side (master) drives syncs and colour; the decoder (slave) drives everything else.
interface vga_sync_decoder_if;
    logic        h_sync;
    logic        v_sync;
    logic [3:0]  r_in;
    logic [3:0]  g_in;
    logic [3:0]  b_in;
    logic        locked;
    logic        lost;
    logic        frame_start;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic [3:0]  pix_r;
    logic [3:0]  pix_g;
    logic [3:0]  pix_b;
    logic [10:0] meas_h_period;
    logic [10:0] meas_v_lines;
    logic [7:0]  err_count;

    modport master (
        output h_sync, v_sync, r_in, g_in, b_in,
        input  locked, lost, frame_start, pix_valid, pix_x, pix_y,
               pix_r, pix_g, pix_b, meas_h_period, meas_v_lines, err_count
    );

    modport slave (
        input  h_sync, v_sync, r_in, g_in, b_in,
        output locked, lost, frame_start, pix_valid, pix_x, pix_y,
               pix_r, pix_g, pix_b, meas_h_period, meas_v_lines, err_count
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: measures line/frame timing, locks after LOCK_FRAMES good frames, emits qualified pixels.
// Pin-to-pixel latency 2 clocks; no backpressure, the pixel stream runs at the source pixel rate.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 1041,
    parameter int V_TOTAL     = 667,
    parameter int H_BP        = 184,
    parameter int H_ACTIVE    = 799,
    parameter int V_BP        = 29,
    parameter int V_ACTIVE    = 599,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              reset,
    vga_sync_decoder_if.slave vga
);
    localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
    localparam logic [10:0] H_BP_C    = 11'(H_BP);
    localparam logic [10:0] H_END_C   = 11'(H_BP + H_ACTIVE);
    localparam logic [10:0] V_BP_C    = 11'(V_BP);
    localparam logic [10:0] V_END_C   = 11'(V_BP + V_ACTIVE);
    localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [3:0]  good_cnt, good_nxt;
    logic        s_hs, s_vs, s_hs_d, s_vs_d;
    logic [11:0] s_rgb;
    logic [10:0] h_cnt, v_line, h_pos, v_line_inc;
    logic        frame_bad, locked_q;
    logic        hs_rise, vs_rise, h_sat, line_bad, frame_good, vis;
    logic        lose, bad_eval;

    assign hs_rise    = s_hs & ~s_hs_d;
    assign vs_rise    = s_vs & ~s_vs_d;
    assign h_pos      = hs_rise ? 11'd0 : h_cnt;
    assign h_sat      = &h_cnt;
    assign line_bad   = hs_rise && (h_cnt != H_TOTAL_C);
    // A line boundary landing on the vs edge still belongs to the frame being closed.
    assign v_line_inc = (hs_rise && !(&v_line)) ? v_line + 11'd1 : v_line;
    assign frame_good = (v_line_inc == V_TOTAL_C) && !frame_bad && !line_bad && !h_sat;
    assign vis        = locked_q && (h_pos >= H_BP_C) && (h_pos < H_END_C)
                                 && (v_line >= V_BP_C) && (v_line < V_END_C);
    assign vga.locked = locked_q;

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        lose      = 1'b0;
        bad_eval  = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_rise) begin
                    state_nxt = CHECK;
                    good_nxt  = 4'd0;
                end
            end
            CHECK: begin
                if (vs_rise) begin
                    if (frame_good) begin
                        good_nxt = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 >= LOCK_C) state_nxt = LOCKED;
                    end else begin
                        good_nxt = 4'd0;
                        bad_eval = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (vs_rise && !frame_good) begin
                    state_nxt = SEARCH;
                    lose      = 1'b1;
                    bad_eval  = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= SEARCH;
            good_cnt          <= 4'd0;
            s_hs              <= 1'b0;
            s_vs              <= 1'b0;
            s_hs_d            <= 1'b0;
            s_vs_d            <= 1'b0;
            s_rgb             <= 12'd0;
            h_cnt             <= 11'd0;
            v_line            <= 11'd0;
            frame_bad         <= 1'b0;
            locked_q          <= 1'b0;
            vga.lost          <= 1'b0;
            vga.frame_start   <= 1'b0;
            vga.pix_valid     <= 1'b0;
            vga.pix_x         <= 11'd0;
            vga.pix_y         <= 11'd0;
            vga.pix_r         <= 4'd0;
            vga.pix_g         <= 4'd0;
            vga.pix_b         <= 4'd0;
            vga.meas_h_period <= 11'd0;
            vga.meas_v_lines  <= 11'd0;
            vga.err_count     <= 8'd0;
        end else begin
            s_hs   <= vga.h_sync;
            s_vs   <= vga.v_sync;
            s_hs_d <= s_hs;
            s_vs_d <= s_vs;
            s_rgb  <= {vga.r_in, vga.g_in, vga.b_in};

            h_cnt <= (&h_pos) ? h_pos : h_pos + 11'd1;
            if (hs_rise) vga.meas_h_period <= h_cnt;

            if (vs_rise) begin
                vga.meas_v_lines <= v_line_inc;
                v_line           <= 11'd0;
                frame_bad        <= 1'b0;
            end else begin
                v_line <= v_line_inc;
                if (line_bad || h_sat) frame_bad <= 1'b1;
            end

            state           <= state_nxt;
            good_cnt        <= good_nxt;
            locked_q        <= (state_nxt == LOCKED);
            vga.lost        <= lose;
            vga.frame_start <= vs_rise;
            if (bad_eval && (vga.err_count != 8'hFF)) vga.err_count <= vga.err_count + 8'd1;

            vga.pix_valid <= vis;
            vga.pix_x     <= vis ? h_pos - H_BP_C : 11'd0;
            vga.pix_y     <= vis ? v_line - V_BP_C : 11'd0;
            {vga.pix_r, vga.pix_g, vga.pix_b} <= vis ? s_rgb : 12'd0;
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down raster (40 clocks x 20 lines) to keep runs short.
// Source: hs high at hc 4..9, vs high on lines 3..5, so pixel (x,y) sits at hc = x+12, vc = y+5.
module tb_vga_sync_decoder;
    localparam int HT = 40, VT = 20, HBP = 8, HACT = 24, VBP = 3, VACT = 12;
    localparam int BUDGET = 3 * HT * VT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_sync_decoder_if vif();

    vga_sync_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_BP(HBP), .H_ACTIVE(HACT),
        .V_BP(VBP), .V_ACTIVE(VACT), .LOCK_FRAMES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vif)
    );

    typedef struct {
        int         vc;
        int         hc;
        logic [11:0] rgb;
        logic       valid;
        int         x;
        int         y;
    } vec_t;

    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;
    int   hc = 0;
    int   vc = 0;
    int   short_vc = -1;
    logic hs_kill = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out after %0d clocks", name, BUDGET);
    endtask

    // Drive one pixel clock of the source raster, then step the raster position.
    task automatic tick(input logic [11:0] rgb);
        vif.h_sync = !hs_kill && (hc >= 4) && (hc <= 9);
        vif.v_sync = (vc >= 3) && (vc <= 5);
        {vif.r_in, vif.g_in, vif.b_in} = rgb;
        @(posedge clk);
        #1;
        if (hc >= ((vc == short_vc) ? HT - 2 : HT - 1)) begin
            hc = 0;
            vc = (vc + 1) % VT;
        end else begin
            hc++;
        end
    endtask

    task automatic run_until(input int tvc, input int thc, input string name);
        int n = 0;
        while (!(vc == tvc && hc == thc) && n < BUDGET) begin
            tick(12'd0);
            n++;
        end
        if (!(vc == tvc && hc == thc)) timeout(name);
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        do begin
            tick(12'd0);
            n++;
        end while (!vif.frame_start && n < BUDGET);
        if (!vif.frame_start) timeout(name);
    endtask

    // locked must stay low through two frame_start pulses and rise with the third.
    task automatic expect_lock(input string name);
        for (int fs = 1; fs <= 3; fs++) begin
            wait_frame($sformatf("%s wait fs%0d", name, fs));
            check($sformatf("%s locked@fs%0d", name, fs), 64'(vif.locked), 64'(fs == 3));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [34:0] exp_pix;
        logic [34:0] act_pix;

        vecs[0] = '{vc: 4,  hc: 12, rgb: 12'habc, valid: 1'b0, x: 0,  y: 0};
        vecs[1] = '{vc: 5,  hc: 10, rgb: 12'h123, valid: 1'b0, x: 0,  y: 0};
        vecs[2] = '{vc: 5,  hc: 12, rgb: 12'hff0, valid: 1'b1, x: 0,  y: 0};
        vecs[3] = '{vc: 5,  hc: 35, rgb: 12'h5a5, valid: 1'b1, x: 23, y: 0};
        vecs[4] = '{vc: 6,  hc: 36, rgb: 12'h777, valid: 1'b0, x: 0,  y: 0};
        vecs[5] = '{vc: 9,  hc: 20, rgb: 12'h3c9, valid: 1'b1, x: 8,  y: 4};
        vecs[6] = '{vc: 12, hc: 4,  rgb: 12'h111, valid: 1'b0, x: 0,  y: 0};
        vecs[7] = '{vc: 16, hc: 12, rgb: 12'he1d, valid: 1'b1, x: 0,  y: 11};
        vecs[8] = '{vc: 16, hc: 35, rgb: 12'h0f0, valid: 1'b1, x: 23, y: 11};
        vecs[9] = '{vc: 17, hc: 35, rgb: 12'h999, valid: 1'b0, x: 0,  y: 0};

        // Reset held with syncs toggling: every output must read zero.
        for (int i = 0; i < 3; i++) begin
            vif.h_sync = i[0];
            vif.v_sync = ~i[0];
            {vif.r_in, vif.g_in, vif.b_in} = 12'hfff;
            @(posedge clk);
            #1;
        end
        check("reset outputs",
              64'({vif.locked, vif.lost, vif.frame_start, vif.pix_valid, vif.pix_x, vif.pix_y,
                   vif.pix_r, vif.pix_g, vif.pix_b, vif.meas_h_period, vif.meas_v_lines,
                   vif.err_count}), 64'd0);
        reset = 1'b0;

        // Nominal source: lock on the third vs edge.
        expect_lock("nominal");
        check("meas_h_period nominal", 64'(vif.meas_h_period), 64'(HT));
        check("meas_v_lines nominal", 64'(vif.meas_v_lines), 64'(VT));
        check("err_count nominal", 64'(vif.err_count), 64'd0);

        // Pixel probes: colour only on the probed clock, result two clocks later.
        foreach (vecs[i]) begin
            run_until(vecs[i].vc, vecs[i].hc, $sformatf("pix%0d reach", i));
            tick(vecs[i].rgb);
            tick(12'd0);
            exp_pix = vecs[i].valid ? {1'b1, 11'(vecs[i].x), 11'(vecs[i].y), vecs[i].rgb} : 35'd0;
            act_pix = {vif.pix_valid, vif.pix_x, vif.pix_y, vif.pix_r, vif.pix_g, vif.pix_b};
            check($sformatf("pix%0d v/x/y/rgb", i), 64'(act_pix), 64'(exp_pix));
        end

        // One 39-clock line while locked: lost at the following vs edge.
        short_vc = 10;
        run_until(11, 6, "short line reach");
        short_vc = -1;
        check("meas_h_period short", 64'(vif.meas_h_period), 64'(HT - 1));
        check("locked before loss", 64'(vif.locked), 64'd1);
        wait_frame("short line frame");
        check("lost pulse", 64'(vif.lost), 64'd1);
        check("locked after loss", 64'(vif.locked), 64'd0);
        check("err_count after loss", 64'(vif.err_count), 64'd1);
        tick(12'd0);
        check("lost one cycle", 64'(vif.lost), 64'd0);

        // Enter CHECK, then starve h_sync for three frames: line counter saturates, no lock.
        wait_frame("search to check");
        hs_kill = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            wait_frame($sformatf("no hsync frame %0d", f));
            check($sformatf("no hsync locked f%0d", f), 64'(vif.locked), 64'd0);
            check($sformatf("no hsync lines f%0d", f), 64'(vif.meas_v_lines), 64'd0);
        end
        check("err_count no hsync", 64'(vif.err_count), 64'd4);
        hs_kill = 1'b0;
        run_until(3, 6, "hsync resume");
        check("meas_h_period saturated", 64'(vif.meas_h_period), 64'd2047);
        expect_lock("after saturation");
        check("err_count after relock", 64'(vif.err_count), 64'd5);

        // Reset mid-line while locked and streaming pixels.
        run_until(8, 20, "mid-line reach");
        check("pix_valid before reset", 64'(vif.pix_valid), 64'd1);
        reset = 1'b1;
        tick(12'd0);
        reset = 1'b0;
        check("locked after reset", 64'(vif.locked), 64'd0);
        check("pix_valid after reset", 64'(vif.pix_valid), 64'd0);
        check("err_count after reset", 64'(vif.err_count), 64'd0);
        expect_lock("after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
